// File: rtl/barrel_shift_pkg.sv
// rtl/barrel_shift_pkg.sv - command field encodings and FSM states for barrel_shift_reg_ctrl
package barrel_shift_pkg;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_SHIFT = 1'b1;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [1:0] MODE_ROT     = 2'b00;
    localparam logic [1:0] MODE_LOG     = 2'b01;
    localparam logic [1:0] MODE_ARITH   = 2'b10;
    localparam logic [1:0] MODE_ROT_ALT = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/barrel_shift_net.sv
// rtl/barrel_shift_net.sv - combinational log2(WIDTH)-stage rotate/logical/arithmetic shifter
module barrel_shift_net
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic [1:0]         mode,
    output logic [WIDTH-1:0]   result
);

    logic rotate;
    logic arith;

    always_comb begin
        rotate = 1'b0;
        arith  = 1'b0;
        case (mode)
            MODE_ROT, MODE_ROT_ALT: rotate = 1'b1;
            MODE_LOG:               ;
            MODE_ARITH:             arith = 1'b1;
            default:                ;
        endcase
    end

    // Stage k moves by 2**k; arithmetic fill reuses the stage MSB, which still holds the original sign.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int S = 1 << k;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] lft;
        logic [WIDTH-1:0] rgt;
        logic [WIDTH-1:0] dout;

        if (k == 0) begin : g_first
            assign din = data;
        end else begin : g_next
            assign din = g_stage[k-1].dout;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i + S < WIDTH) begin : g_r_in
                assign rgt[i] = din[i+S];
            end else begin : g_r_fill
                assign rgt[i] = rotate ? din[i+S-WIDTH] : (arith & din[WIDTH-1]);
            end
            if (i >= S) begin : g_l_in
                assign lft[i] = din[i-S];
            end else begin : g_l_fill
                assign lft[i] = rotate & din[i-S+WIDTH];
            end
        end

        assign dout = shamt[k] ? ((dir == DIR_LEFT) ? lft : rgt) : din;
    end

    assign result = g_stage[SHAMT_W-1].dout;

endmodule

// File: rtl/barrel_shift_reg_ctrl.sv
// rtl/barrel_shift_reg_ctrl.sv - load/repeat-shift register with valid/ready command port (optional BARREL_SHIFT_REG_ABORT_EN)
module barrel_shift_reg_ctrl
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
`ifdef BARREL_SHIFT_REG_ABORT_EN
    input  logic               abort,
`endif
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   repeat_cnt,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   remaining, remaining_nxt;
    logic [SHAMT_W-1:0] lat_shamt, lat_shamt_nxt;
    logic               lat_dir, lat_dir_nxt;
    logic [1:0]         lat_mode, lat_mode_nxt;
    logic [WIDTH-1:0]   data_nxt;
    logic               done_nxt;
    logic               abort_hit;

    logic [SHAMT_W-1:0] net_shamt;
    logic               net_dir;
    logic [1:0]         net_mode;
    logic [WIDTH-1:0]   step_result;

`ifdef BARREL_SHIFT_REG_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign busy      = (state == ST_RUN);
    assign cmd_ready = ~busy;

    // Step 1 is applied on the accept edge straight from the command fields.
    assign net_shamt = busy ? lat_shamt : shamt;
    assign net_dir   = busy ? lat_dir   : dir;
    assign net_mode  = busy ? lat_mode  : mode;

    barrel_shift_net #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_net (
        .data   (data_out),
        .shamt  (net_shamt),
        .dir    (net_dir),
        .mode   (net_mode),
        .result (step_result)
    );

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        lat_shamt_nxt = lat_shamt;
        lat_dir_nxt   = lat_dir;
        lat_mode_nxt  = lat_mode;
        data_nxt      = data_out;
        done_nxt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            data_nxt = data_in;
                            done_nxt = 1'b1;
                        end
                        OP_SHIFT: begin
                            lat_shamt_nxt = shamt;
                            lat_dir_nxt   = dir;
                            lat_mode_nxt  = mode;
                            if (repeat_cnt == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                data_nxt = step_result;
                                if (repeat_cnt == CNT_W'(1)) begin
                                    done_nxt = 1'b1;
                                end else begin
                                    state_nxt     = ST_RUN;
                                    remaining_nxt = repeat_cnt - CNT_W'(1);
                                end
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (abort_hit) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    data_nxt      = step_result;
                    remaining_nxt = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            lat_shamt <= '0;
            lat_dir   <= 1'b0;
            lat_mode  <= 2'b00;
            data_out  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            lat_shamt <= lat_shamt_nxt;
            lat_dir   <= lat_dir_nxt;
            lat_mode  <= lat_mode_nxt;
            data_out  <= data_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_barrel_shift_reg_ctrl.sv
// tb/tb_barrel_shift_reg_ctrl.sv - scoreboard bench for barrel_shift_reg_ctrl (WIDTH=8)
module tb_barrel_shift_reg_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [2:0] shamt = 3'd0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] repeat_cnt = 8'd0;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
`ifdef BARREL_SHIFT_REG_ABORT_EN
    logic       abort = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    barrel_shift_reg_ctrl #(.WIDTH(8), .SHAMT_W(3), .CNT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef BARREL_SHIFT_REG_ABORT_EN
        .abort      (abort),
`endif
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .data_in    (data_in),
        .shamt      (shamt),
        .dir        (dir),
        .mode       (mode),
        .repeat_cnt (repeat_cnt),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got data_out %0h expected no done", data_out);
            end else begin
                chk("done_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic op, input logic [7:0] d, input logic [2:0] sh,
                        input logic dr, input logic [1:0] md, input logic [7:0] r);
        @(negedge clk);
        cmd_op = op; data_in = d; shamt = sh; dir = dr; mode = md; repeat_cnt = r;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        chk({"timeout_", name}, 32'(n < 40), 32'd1);
    endtask

    task automatic load(input logic [7:0] d);
        exp_q.push_back(d);
        send(1'b0, d, 3'd0, 1'b0, 2'b00, 8'd0);
        wait_done("load");
    endtask

    task automatic shift(input string name, input logic [2:0] sh, input logic dr,
                         input logic [1:0] md, input logic [7:0] r, input logic [7:0] exp);
        exp_q.push_back(exp);
        send(1'b1, 8'h00, sh, dr, md, r);
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq [4];
        seq[0] = 8'h03; seq[1] = 8'h06; seq[2] = 8'h0C; seq[3] = 8'h18;

        #1;
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Rotate left 1 x3 on 0xA5
        load(8'hA5);
        exp_q.push_back(8'h2D);
        send(1'b1, 8'h00, 3'd1, 1'b0, 2'b00, 8'd3);
        @(negedge clk);
        chk("rotl_s1", 32'(data_out), 32'h4B);
        chk("rotl_busy1", 32'(busy), 32'd1);
        chk("rotl_ready1", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("rotl_s2", 32'(data_out), 32'h96);
        chk("rotl_busy2", 32'(busy), 32'd1);
        wait_done("rotl");
        chk("rotl_busy_end", 32'(busy), 32'd0);

        load(8'h90);
        shift("asr2", 3'd2, 1'b1, 2'b10, 8'd1, 8'hE4);
        load(8'h90);
        shift("lsr2", 3'd2, 1'b1, 2'b01, 8'd1, 8'h24);
        load(8'h90);
        shift("rotr4", 3'd4, 1'b1, 2'b00, 8'd1, 8'h09);
        load(8'h90);
        shift("rot_alias", 3'd4, 1'b0, 2'b11, 8'd1, 8'h09);
        load(8'h81);
        shift("asl1", 3'd1, 1'b0, 2'b10, 8'd1, 8'h02);

        // Logical left 3 from 0x01
        load(8'h01);
        exp_q.push_back(8'h40);
        send(1'b1, 8'h00, 3'd3, 1'b0, 2'b01, 8'd2);
        @(negedge clk);
        chk("lsl_s1", 32'(data_out), 32'h08);
        wait_done("lsl2");
        load(8'h01);
        shift("lsl3_zero", 3'd3, 1'b0, 2'b01, 8'd3, 8'h00);

        // Inputs toggled and valid held during RUN must be ignored
        load(8'h81);
        exp_q.push_back(8'h30);
        @(negedge clk);
        cmd_op = 1'b1; data_in = 8'h00; shamt = 3'd1; dir = 1'b0; mode = 2'b00; repeat_cnt = 8'd5;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_op = 1'b0; data_in = 8'hFF; shamt = 3'd3; dir = 1'b1; mode = 2'b01; repeat_cnt = 8'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_ready", 32'(cmd_ready), 32'd0);
            chk("hold_data", 32'(data_out), 32'(seq[i]));
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        wait_done("hold");

        // R = 0 is a no-op that still pulses done
        load(8'h3C);
        shift("r0", 3'd5, 1'b1, 2'b01, 8'd0, 8'h3C);
        chk("r0_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of RUN
        load(8'hFF);
        send(1'b1, 8'h00, 3'd1, 1'b0, 2'b01, 8'd10);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_data", 32'(data_out), 32'h00);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_data", 32'(data_out), 32'h00);

`ifdef BARREL_SHIFT_REG_ABORT_EN
        load(8'h01);
        send(1'b1, 8'h00, 3'd1, 1'b0, 2'b00, 8'd6);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back(8'h08);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_done("abort");
        chk("abort_busy", 32'(busy), 32'd0);
        load(8'h11);
        chk("abort_idle_load", 32'(data_out), 32'h11);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
